// File: rtl/spi_sensor_sequencer.sv
// Command sequencer for an SPI master. It writes two sensor configuration registers,
// then periodically reads a block of data registers and packs each block into one sample word.
module spi_sensor_sequencer #(
  parameter logic [5:0] CFG0_ADDR = 6'h2D,
  parameter logic [7:0] CFG0_DATA = 8'h08,
  parameter logic [5:0] CFG1_ADDR = 6'h31,
  parameter logic [7:0] CFG1_DATA = 8'h0B,
  parameter logic [5:0] BASE_ADDR = 6'h32,
  parameter int         NUM_BYTES = 6,
  parameter int         PERIOD    = 100000,
  parameter int         TIMEOUT   = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   spi_busy,
  input  logic [7:0]             spi_rdata,
  output logic                   spi_en,
  output logic                   spi_rw,
  output logic [5:0]             spi_address,
  output logic [7:0]             spi_wdata,
  output logic [8*NUM_BYTES-1:0] sample,
  output logic                   sample_valid,
  output logic                   init_done,
  output logic                   timeout_err,
  output logic                   active
);

  localparam int PER_W = $clog2(PERIOD + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, INIT0, INIT1, RD, WAIT} state_t;
  // PH_REQ holds en while waiting for busy to rise; PH_BUSY waits for busy to fall.
  typedef enum logic {PH_REQ, PH_BUSY} phase_t;

  state_t                 state, state_nxt;
  phase_t                 phase, phase_nxt;
  logic [2:0]             idx;
  logic [PER_W-1:0]       per_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [8*NUM_BYTES-1:0] rd_buf, burst_word;

  logic xact_done, cap_byte, last_byte, burst_go, idx_inc, init_set, to_clr, to_fire;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    xact_done = 1'b0;
    cap_byte  = 1'b0;
    last_byte = 1'b0;
    burst_go  = 1'b0;
    idx_inc   = 1'b0;
    init_set  = 1'b0;
    to_clr    = 1'b0;
    to_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          phase_nxt = PH_REQ;
          to_clr    = 1'b1;
          if (init_done) begin
            state_nxt = RD;
            burst_go  = 1'b1;
          end else begin
            state_nxt = INIT0;
          end
        end
      end
      WAIT: begin
        if (!start) begin
          state_nxt = IDLE;
        end else if (per_cnt == '0) begin
          state_nxt = RD;
          phase_nxt = PH_REQ;
          burst_go  = 1'b1;
          to_clr    = 1'b1;
        end
      end
      default: begin
        if (phase == PH_REQ) begin
          if (spi_busy) begin
            phase_nxt = PH_BUSY;
            to_clr    = 1'b1;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            to_fire = 1'b1;
          end
        end else begin
          if (!spi_busy) begin
            xact_done = 1'b1;
            to_clr    = 1'b1;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            to_fire = 1'b1;
          end
        end

        if (xact_done) begin
          phase_nxt = PH_REQ;
          case (state)
            INIT0: state_nxt = INIT1;
            INIT1: begin
              state_nxt = RD;
              init_set  = 1'b1;
              burst_go  = 1'b1;
            end
            default: begin
              cap_byte = 1'b1;
              if (idx == 3'(NUM_BYTES - 1)) begin
                last_byte = 1'b1;
                // A burst that overran the period starts the next one straight away.
                if (per_cnt == '0) burst_go = 1'b1;
                else               state_nxt = WAIT;
              end else begin
                idx_inc = 1'b1;
              end
            end
          endcase
          if (!start) state_nxt = IDLE;
        end

        if (to_fire) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    burst_word = rd_buf;
    burst_word[8*idx +: 8] = spi_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  // NOTE: the read buffer is reset along with everything else so a partial first
  // burst can never leak stale bytes; it is a handful of flops, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_REQ;
      idx          <= '0;
      per_cnt      <= '0;
      to_cnt       <= '0;
      rd_buf       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      sample_valid <= last_byte;

      if (burst_go)     idx <= '0;
      else if (idx_inc) idx <= idx + 3'd1;

      if (burst_go)
        per_cnt <= PER_W'(PERIOD - 1);
      else if ((state == RD || state == WAIT) && per_cnt != '0)
        per_cnt <= per_cnt - PER_W'(1);

      if (to_clr || state == IDLE || state == WAIT) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + TO_W'(1);

      if (cap_byte)  rd_buf <= burst_word;
      if (last_byte) sample <= burst_word;

      if (to_fire) begin
        timeout_err <= 1'b1;
        init_done   <= 1'b0;
      end else if (init_set) begin
        init_done <= 1'b1;
      end
    end
  end

  always_comb begin
    spi_en      = 1'b0;
    spi_rw      = 1'b0;
    spi_address = '0;
    spi_wdata   = '0;
    case (state)
      INIT0: begin
        spi_en      = (phase == PH_REQ);
        spi_address = CFG0_ADDR;
        spi_wdata   = CFG0_DATA;
      end
      INIT1: begin
        spi_en      = (phase == PH_REQ);
        spi_address = CFG1_ADDR;
        spi_wdata   = CFG1_DATA;
      end
      RD: begin
        spi_en      = (phase == PH_REQ);
        spi_rw      = 1'b1;
        spi_address = BASE_ADDR + 6'(idx);
      end
      default: ;
    endcase
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_spi_sensor_sequencer.sv
// Directed bench for spi_sensor_sequencer: a behavioural SPI master answers each request,
// and a linear sequence of steps checks init, burst assembly, period, restart, timeout and reset.
module tb_spi_sensor_sequencer;

  localparam int NB      = 6;
  localparam int PERIOD  = 200;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          spi_busy = 1'b0;
  logic [7:0]    spi_rdata = '0;
  logic          spi_en, spi_rw, sample_valid, init_done, timeout_err, active;
  logic [5:0]    spi_address;
  logic [7:0]    spi_wdata;
  logic [8*NB-1:0] sample;

  spi_sensor_sequencer #(.NUM_BYTES(NB), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .spi_busy(spi_busy), .spi_rdata(spi_rdata),
    .spi_en(spi_en), .spi_rw(spi_rw), .spi_address(spi_address), .spi_wdata(spi_wdata),
    .sample(sample), .sample_valid(sample_valid), .init_done(init_done),
    .timeout_err(timeout_err), .active(active)
  );

  always #5 clk = ~clk;

  // Behavioural SPI master: busy rises 3 cycles after en is seen and lasts 20 cycles.
  logic [5:0] log_addr[$];
  logic       log_rw[$];
  logic [7:0] log_wdata[$];
  logic       hang = 1'b0;
  logic [7:0] data_xor = 8'h00;

  initial begin
    logic [5:0] a;
    forever begin
      @(negedge clk);
      if (spi_en && !rst) begin
        a = spi_address;
        log_addr.push_back(a);
        log_rw.push_back(spi_rw);
        log_wdata.push_back(spi_wdata);
        if (hang && spi_rw && a == 6'h34) begin
          while (spi_en) @(negedge clk);
        end else begin
          repeat (3) @(negedge clk);
          spi_busy = 1'b1;
          repeat (20) @(negedge clk);
          spi_rdata = (8'(a - 6'h32) + 8'd1) * 8'h11 ^ data_xor;
          spi_busy  = 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_rises = 0;
  int busy_falls = 0;
  int en_run   = 0;
  int last_run = 0;
  logic prev_en = 1'b0, prev_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // One sampling point per cycle, away from the active edge, with simple activity monitors.
  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (spi_en && !prev_en) en_rises++;
    if (!spi_busy && prev_busy) busy_falls++;
    if (spi_en) en_run++;
    else if (prev_en) begin
      last_run = en_run;
      en_run   = 0;
    end
    prev_en   = spi_en;
    prev_busy = spi_busy;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int at);
    int n;
    n = 0;
    while (!sample_valid && n < budget) begin
      tick();
      n++;
    end
    at = cyc;
    check(tag, {63'd0, sample_valid}, 64'd1);
  endtask

  initial begin
    int v1, v2, lsz, n, init_rise_falls;
    logic seen_init;

    // Reset state
    repeat (3) tick();
    check("rst_en", {63'd0, spi_en}, 64'd0);
    check("rst_active", {63'd0, active}, 64'd0);
    check("rst_sample", 64'(sample), 64'd0);
    check("rst_flags", {61'd0, sample_valid, init_done, timeout_err}, 64'd0);
    check("rst_addr_wdata", {50'd0, spi_address, spi_wdata}, 64'd0);

    // Init writes then first burst
    rst = 1'b0;
    start = 1'b1;
    seen_init = 1'b0;
    init_rise_falls = -1;
    n = 0;
    while (!sample_valid && n < 2000) begin
      tick();
      n++;
      if (init_done && !seen_init) begin
        seen_init = 1'b1;
        init_rise_falls = busy_falls;
      end
    end
    check("first_valid", {63'd0, sample_valid}, 64'd1);
    v1 = cyc;
    check("init_after_2nd_fall", 64'(init_rise_falls), 64'd2);
    check("log_len_first", 64'(log_addr.size()), 64'd8);
    if (log_addr.size() >= 8) begin
      check("init0_xact", {49'd0, log_addr[0], log_rw[0], log_wdata[0]}, {49'd0, 6'h2D, 1'b0, 8'h08});
      check("init1_xact", {49'd0, log_addr[1], log_rw[1], log_wdata[1]}, {49'd0, 6'h31, 1'b0, 8'h0B});
      for (int k = 0; k < 6; k++)
        check($sformatf("read%0d", k), {57'd0, log_addr[2+k], log_rw[2+k]}, {57'd0, 6'h32 + 6'(k), 1'b1});
    end
    check("sample1", 64'(sample), 64'h665544332211);
    check("init_done_1", {63'd0, init_done}, 64'd1);
    tick();
    check("valid_one_cycle", {63'd0, sample_valid}, 64'd0);

    // Period spacing
    wait_valid("second_valid", 1000, v2);
    check("period_spacing", 64'(v2 - v1), 64'(PERIOD));
    check("en_one_per_xact", 64'(en_rises), 64'(log_addr.size()));
    check("log_len_second", 64'(log_addr.size()), 64'd14);

    // Drop start in WAIT, raise again 50 cycles later: no init rerun
    repeat (5) tick();
    start = 1'b0;
    tick();
    check("idle_on_stop", {63'd0, active}, 64'd0);
    repeat (50) tick();
    lsz = log_addr.size();
    start = 1'b1;
    n = 0;
    while (log_addr.size() == lsz && n < 100) begin
      tick();
      n++;
    end
    check("restart_logged", 64'(log_addr.size() > lsz), 64'd1);
    if (log_addr.size() > lsz)
      check("restart_first_read", {57'd0, log_addr[lsz], log_rw[lsz]}, {57'd0, 6'h32, 1'b1});
    wait_valid("restart_valid", 1000, v1);
    check("restart_sample", 64'(sample), 64'h665544332211);

    // Timeout on the third read of the next burst
    tick();
    hang = 1'b1;
    data_xor = 8'hF0;
    n = 0;
    while (!timeout_err && n < 1000) begin
      tick();
      n++;
    end
    check("timeout_flag", {63'd0, timeout_err}, 64'd1);
    check("timeout_en_hold", 64'(last_run), 64'(TIMEOUT));
    check("timeout_en_low", {63'd0, spi_en}, 64'd0);
    check("timeout_idle", {63'd0, active}, 64'd0);
    check("timeout_sample_kept", 64'(sample), 64'h665544332211);
    check("timeout_init_clr", {63'd0, init_done}, 64'd0);
    check("timeout_no_valid", {63'd0, sample_valid}, 64'd0);

    // Rerun after timeout redoes init and completes a burst; flag stays set
    hang = 1'b0;
    data_xor = 8'h00;
    lsz = log_addr.size();
    wait_valid("post_timeout_valid", 2000, v1);
    if (log_addr.size() > lsz)
      check("init_redone", {50'd0, log_addr[lsz], log_wdata[lsz]}, {50'd0, 6'h2D, 8'h08});
    check("timeout_sticky", {63'd0, timeout_err}, 64'd1);

    // Reset during a read's busy-low wait
    n = 0;
    while (!(spi_rw && spi_busy && !spi_en) && n < 1000) begin
      tick();
      n++;
    end
    check("found_busy_lo", {63'd0, spi_rw && spi_busy && !spi_en}, 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_en", {63'd0, spi_en}, 64'd0);
    check("midrst_active", {63'd0, active}, 64'd0);
    check("midrst_sample", 64'(sample), 64'd0);
    check("midrst_flags", {62'd0, init_done, timeout_err}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
